seq_decode: RTL and testbench
=============================

// Module: seq_decode
// PURPOSE
//   Control unit for the accumulator CPU: owns the FETCH/EXEC1/EXEC2 phase state machine and
//   decodes the opcode into datapath strobes for PC, accumulator, RAM and muxes. Adds run/halt
//   control, single-step mode, illegal-opcode trapping and internal EQ/MI flag generation from
//   an accumulator of any width. Sits between the IR/ACC registers and the PC/RAM/ALU datapath.
// PARAMETERS
//   DATA_W  8  accumulator width; EQ = (ACC == 0), MI = ACC[DATA_W-1]
//   OPC_W   4  opcode width (>=4); any nonzero bit above bit 3 makes the opcode illegal
// PORTS
//   CLK        in   1       rising-edge clock
//   RESET      in   1       asynchronous, active-high reset
//   RUN        in   1       start/resume; only the rising edge acts (internally registered)
//   STEP_MODE  in   1       1 = pause in IDLE after each completed instruction
//   IR         in   OPC_W   opcode; must be stable from EXEC1 to the end of the instruction
//   ACC        in   DATA_W  accumulator value, used for the EQ/MI flags
//   FETCH      out  1       phase strobe, registered, one-hot with EXEC1/EXEC2
//   EXEC1      out  1       phase strobe
//   EXEC2      out  1       phase strobe
//   IR_LOAD    out  1       load IR from RAM; equals FETCH
//   EXTRA      out  1       instruction needs EXEC2
//   Wren       out  1       RAM write enable
//   MUX1       out  1       RAM address = IR operand (else PC)
//   MUX3       out  1       accumulator source = RAM/immediate (else ALU)
//   PC_sload   out  1       PC load (jump taken)
//   PC_cnt_en  out  1       PC increment
//   ACC_EN     out  1       accumulator enable
//   ACC_LOAD   out  1       accumulator parallel load
//   ADDSUB     out  1       ALU mode: 1 = add, 0 = subtract
//   HALTED     out  1       registered; 1 while in HALT
//   ILLEGAL    out  1       sticky; set in EXEC1 of an illegal opcode, cleared only by RESET
// BEHAVIOUR
//   Opcodes: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 JMP, 5 JMI, 6 JEQ, 7 STP, 8 LDI; 9..15 are illegal.
//   States: IDLE, FETCH, EXEC1, EXEC2, HALT. Reset enters IDLE. In IDLE, HALT and on reset,
//     every output is 0 except HALTED (1 only in HALT); ILLEGAL is 0 after reset.
//   The edge detector compares RUN with RUN_q (RUN_q resets to 0). A RUN level held through
//     reset release counts as a rising edge on the first clock after release.
//   Transitions:
//     IDLE -> FETCH on a RUN rising edge.
//     FETCH -> EXEC1.
//     EXEC1 -> EXEC2 if EXTRA; -> HALT if STP; otherwise instruction complete.
//     EXEC2 -> instruction complete.
//     Instruction complete -> FETCH, or -> IDLE if STEP_MODE=1 (sampled in the completing cycle).
//     HALT -> FETCH on a RUN rising edge. The PC already points past STP.
//   Strobes are combinational from state, IR and flags, so they are valid in the same cycle:
//     EXTRA     = EXEC1 & (LDA|ADD|SUB)
//     MUX1      = EXEC1 & (LDA|STA|ADD|SUB)
//     Wren      = EXEC1 & STA
//     MUX3      = EXEC2&LDA | EXEC1&LDI
//     ACC_EN    = ACC_LOAD = EXEC2&(LDA|ADD|SUB) | EXEC1&LDI
//     ADDSUB    = EXEC2 & ADD
//     PC_sload  = EXEC1 & (JMP | JMI&MI | JEQ&EQ)
//     PC_cnt_en = EXEC2&(LDA|ADD|SUB) | EXEC1&(STA|LDI|STP|illegal | JMI&!MI | JEQ&!EQ)
//   PC_sload and PC_cnt_en are never both 1.
//   Illegal opcode: executes as a 2-cycle NOP (PC increments once in EXEC1) and sets ILLEGAL.
//   Flags are sampled combinationally from ACC during EXEC1 only.
//   Latency: 2 cycles for STA/JMP/JMI/JEQ/LDI/STP/illegal, 3 cycles for LDA/ADD/SUB.
//   RESET asserted mid-instruction: the block returns to IDLE asynchronously, all strobes drop
//     at once, and no partial Wren/ACC_EN is held.
// TESTING
//   1 Reset, RUN edge, IR=8 (LDI): FETCH, EXEC1 with MUX3=ACC_EN=ACC_LOAD=PC_cnt_en=1,
//     then FETCH again.
//   2 IR=2 (ADD): 3-cycle instruction; EXTRA=MUX1=1 in EXEC1; ADDSUB=ACC_EN=PC_cnt_en=1 in EXEC2.
//     Repeat with IR=3 (SUB): ADDSUB=0.
//   3 DATA_W=16, IR=6 (JEQ): ACC=16'h0000 -> PC_sload=1; ACC=16'h0100 -> PC_cnt_en=1.
//     IR=5 (JMI): ACC=16'h8000 -> PC_sload=1.
//   4 IR=7 (STP): HALT and HALTED=1 after EXEC1; RUN held high stays halted; a new RUN edge
//     -> FETCH.
//   5 STEP_MODE=1 with two ADDs: IDLE after each instruction; each RUN pulse runs exactly
//     one instruction.
//   6 IR=4'hB: NOP with PC_cnt_en=1 and ILLEGAL=1 sticky. RESET during EXEC1 of STA
//     -> Wren=0 at once, IDLE.

Source files
------------

// File: rtl/seq_decode.sv
// Phase sequencer and opcode decoder for the accumulator CPU.
// State | meaning: IDLE wait RUN edge | FETCH load IR | EXEC1 decode/execute | EXEC2 memory-data cycle | HALT stopped by STP
module seq_decode #(
   parameter int DATA_W = 8,
   parameter int OPC_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic              step_mode_i,
   input  logic [OPC_W-1:0]  ir_i,
   input  logic [DATA_W-1:0] acc_i,
   output logic              fetch_o,
   output logic              exec1_o,
   output logic              exec2_o,
   output logic              ir_load_o,
   output logic              extra_o,
   output logic              wren_o,
   output logic              mux1_o,
   output logic              mux3_o,
   output logic              pc_sload_o,
   output logic              pc_cnt_en_o,
   output logic              acc_en_o,
   output logic              acc_load_o,
   output logic              addsub_o,
   output logic              halted_o,
   output logic              illegal_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC1 = 3'd2;
   localparam logic [2:0] S_EXEC2 = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             run_q;
   logic             illegal_q, illegal_d;
   logic             run_rise;
   logic [OPC_W-1:0] ir_hi;
   logic             hi_nz;
   logic [3:0]       lo;
   logic             op_lda, op_sta, op_add, op_sub, op_jmp, op_jmi, op_jeq, op_stp, op_ldi;
   logic             op_ill, op_rd;
   logic             flag_eq, flag_mi;
   logic             st_fetch, st_exec1, st_exec2, st_halt;

   assign run_rise = run_i & ~run_q;

   // Any set bit above the 4-bit opcode field makes the instruction illegal.
   assign ir_hi  = ir_i >> 4;
   assign hi_nz  = |ir_hi;
   assign lo     = ir_i[3:0];
   assign op_lda = ~hi_nz & (lo == 4'd0);
   assign op_sta = ~hi_nz & (lo == 4'd1);
   assign op_add = ~hi_nz & (lo == 4'd2);
   assign op_sub = ~hi_nz & (lo == 4'd3);
   assign op_jmp = ~hi_nz & (lo == 4'd4);
   assign op_jmi = ~hi_nz & (lo == 4'd5);
   assign op_jeq = ~hi_nz & (lo == 4'd6);
   assign op_stp = ~hi_nz & (lo == 4'd7);
   assign op_ldi = ~hi_nz & (lo == 4'd8);
   assign op_ill = hi_nz | (lo > 4'd8);
   assign op_rd  = op_lda | op_add | op_sub;

   assign flag_eq = (acc_i == '0);
   assign flag_mi = acc_i[DATA_W-1];

   assign st_fetch = (state_q == S_FETCH);
   assign st_exec1 = (state_q == S_EXEC1);
   assign st_exec2 = (state_q == S_EXEC2);
   assign st_halt  = (state_q == S_HALT);

   assign fetch_o     = st_fetch;
   assign exec1_o     = st_exec1;
   assign exec2_o     = st_exec2;
   assign ir_load_o   = st_fetch;
   assign halted_o    = st_halt;
   assign illegal_o   = illegal_q;
   assign extra_o     = st_exec1 & op_rd;
   assign mux1_o      = st_exec1 & (op_rd | op_sta);
   assign wren_o      = st_exec1 & op_sta;
   assign mux3_o      = (st_exec2 & op_lda) | (st_exec1 & op_ldi);
   assign acc_en_o    = (st_exec2 & op_rd) | (st_exec1 & op_ldi);
   assign acc_load_o  = acc_en_o;
   assign addsub_o    = st_exec2 & op_add;
   assign pc_sload_o  = st_exec1 & (op_jmp | (op_jmi & flag_mi) | (op_jeq & flag_eq));
   assign pc_cnt_en_o = (st_exec2 & op_rd)
                      | (st_exec1 & (op_sta | op_ldi | op_stp | op_ill
                                     | (op_jmi & ~flag_mi) | (op_jeq & ~flag_eq)));

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q | (st_exec1 & op_ill);
      case (state_q)
         S_IDLE:  if (run_rise) state_d = S_FETCH;
         S_FETCH: state_d = S_EXEC1;
         S_EXEC1: begin
            if (op_rd)            state_d = S_EXEC2;
            else if (op_stp)      state_d = S_HALT;
            else if (step_mode_i) state_d = S_IDLE;
            else                  state_d = S_FETCH;
         end
         S_EXEC2: state_d = step_mode_i ? S_IDLE : S_FETCH;
         S_HALT:  if (run_rise) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         run_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_i;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_seq_decode.sv
// Self-checking bench for seq_decode: directed table, corner sequences and random instructions.
module tb_seq_decode;

   localparam int DATA_W = 16;
   localparam int OPC_W  = 4;

   localparam logic [13:0] B_FETCH = 14'h2000;
   localparam logic [13:0] B_E1    = 14'h1000;
   localparam logic [13:0] B_E2    = 14'h0800;
   localparam logic [13:0] B_IRL   = 14'h0400;
   localparam logic [13:0] B_EXTRA = 14'h0200;
   localparam logic [13:0] B_WREN  = 14'h0100;
   localparam logic [13:0] B_MUX1  = 14'h0080;
   localparam logic [13:0] B_MUX3  = 14'h0040;
   localparam logic [13:0] B_SLOAD = 14'h0020;
   localparam logic [13:0] B_CNT   = 14'h0010;
   localparam logic [13:0] B_AEN   = 14'h0008;
   localparam logic [13:0] B_ALD   = 14'h0004;
   localparam logic [13:0] B_ADD   = 14'h0002;
   localparam logic [13:0] B_HALT  = 14'h0001;

   logic              clk = 1'b0;
   logic              rst;
   logic              run;
   logic              step;
   logic [OPC_W-1:0]  ir;
   logic [DATA_W-1:0] acc;
   logic fetch, exec1, exec2, ir_load, extra, wren, mux1, mux3;
   logic pc_sload, pc_cnt_en, acc_en, acc_load, addsub, halted, illegal;
   logic [13:0] obs;

   int total = 0;
   int bad   = 0;
   logic exp_illegal = 1'b0;

   always #5 clk = ~clk;

   seq_decode #(.DATA_W(DATA_W), .OPC_W(OPC_W)) dut (
      .clk_i(clk), .rst_i(rst), .run_i(run), .step_mode_i(step), .ir_i(ir), .acc_i(acc),
      .fetch_o(fetch), .exec1_o(exec1), .exec2_o(exec2), .ir_load_o(ir_load),
      .extra_o(extra), .wren_o(wren), .mux1_o(mux1), .mux3_o(mux3),
      .pc_sload_o(pc_sload), .pc_cnt_en_o(pc_cnt_en), .acc_en_o(acc_en),
      .acc_load_o(acc_load), .addsub_o(addsub), .halted_o(halted), .illegal_o(illegal)
   );

   assign obs = {fetch, exec1, exec2, ir_load, extra, wren, mux1, mux3,
                 pc_sload, pc_cnt_en, acc_en, acc_load, addsub, halted};

   typedef struct {
      logic [OPC_W-1:0]  opc;
      logic [DATA_W-1:0] acc;
      logic [13:0]       exp1;
      logic [13:0]       exp2;
      logic              two;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Semantic model: what each instruction class must drive in each execute phase.
   function automatic logic [13:0] model_vec(input int phase, input logic [OPC_W-1:0] opc,
                                             input logic [DATA_W-1:0] a);
      logic [13:0] v;
      int op;
      bit legal, mem_rd, taken;
      op     = int'(opc);
      legal  = (op <= 8);
      mem_rd = (op == 0 || op == 2 || op == 3);
      if (phase == 2) begin
         v = B_E2 | B_CNT | B_AEN | B_ALD;
         if (op == 0) v |= B_MUX3;
         if (op == 2) v |= B_ADD;
         return v;
      end
      v = B_E1;
      if (!legal) return v | B_CNT;
      if (mem_rd) v |= B_EXTRA | B_MUX1;
      taken = (op == 4) || (op == 5 && a[DATA_W-1]) || (op == 6 && a == 0);
      case (op)
         1: v |= B_MUX1 | B_WREN | B_CNT;
         4, 5, 6: v |= taken ? B_SLOAD : B_CNT;
         7: v |= B_CNT;
         8: v |= B_MUX3 | B_AEN | B_ALD | B_CNT;
         default: ;
      endcase
      return v;
   endfunction

   // Runs one instruction starting from a FETCH cycle, checking each phase against exp1/exp2.
   task automatic run_instr(input string name, input logic [OPC_W-1:0] opc,
                            input logic [DATA_W-1:0] a, input logic sm,
                            input logic [13:0] exp1, input logic [13:0] exp2, input logic two);
      ir = opc; acc = a; step = sm;
      #1;
      chk({name, "_fetch"}, obs, B_FETCH | B_IRL);
      tick();
      chk({name, "_exec1"}, obs, exp1);
      if (int'(opc) > 8) exp_illegal = 1'b1;
      if (two) begin
         tick();
         chk({name, "_exec2"}, obs, exp2);
      end
      tick();
      if (opc == 4'd7)  chk({name, "_halt"}, obs, B_HALT);
      else if (sm)      chk({name, "_idle"}, obs, 14'h0);
      chk({name, "_illegal"}, {13'h0, illegal}, {13'h0, exp_illegal});
   endtask

   task automatic run_model(input string name, input logic [OPC_W-1:0] opc,
                            input logic [DATA_W-1:0] a, input logic sm);
      logic two;
      two = (opc == 4'd0 || opc == 4'd2 || opc == 4'd3);
      run_instr(name, opc, a, sm, model_vec(1, opc, a), model_vec(2, opc, a), two);
   endtask

   // From HALT or IDLE with RUN high: drop RUN for one cycle, then raise it.
   task automatic resume(input string name);
      run = 1'b0;
      tick();
      run = 1'b1;
      tick();
      chk({name, "_resume"}, obs, B_FETCH | B_IRL);
   endtask

   initial begin
      tbl[0]  = '{4'd8, 16'h1234, B_E1|B_MUX3|B_AEN|B_ALD|B_CNT, 14'h0, 1'b0};
      tbl[1]  = '{4'd2, 16'h0001, B_E1|B_EXTRA|B_MUX1, B_E2|B_CNT|B_AEN|B_ALD|B_ADD, 1'b1};
      tbl[2]  = '{4'd3, 16'h0001, B_E1|B_EXTRA|B_MUX1, B_E2|B_CNT|B_AEN|B_ALD, 1'b1};
      tbl[3]  = '{4'd0, 16'h0000, B_E1|B_EXTRA|B_MUX1, B_E2|B_MUX3|B_CNT|B_AEN|B_ALD, 1'b1};
      tbl[4]  = '{4'd1, 16'h5555, B_E1|B_MUX1|B_WREN|B_CNT, 14'h0, 1'b0};
      tbl[5]  = '{4'd4, 16'h0100, B_E1|B_SLOAD, 14'h0, 1'b0};
      tbl[6]  = '{4'd6, 16'h0000, B_E1|B_SLOAD, 14'h0, 1'b0};
      tbl[7]  = '{4'd6, 16'h0100, B_E1|B_CNT, 14'h0, 1'b0};
      tbl[8]  = '{4'd5, 16'h8000, B_E1|B_SLOAD, 14'h0, 1'b0};
      tbl[9]  = '{4'd5, 16'h7FFF, B_E1|B_CNT, 14'h0, 1'b0};
      tbl[10] = '{4'd6, 16'hFFFF, B_E1|B_CNT, 14'h0, 1'b0};
      tbl[11] = '{4'd5, 16'h0000, B_E1|B_CNT, 14'h0, 1'b0};

      rst = 1'b1; run = 1'b0; step = 1'b0; ir = '0; acc = '0;
      tick();
      chk("reset_outputs", obs, 14'h0);
      chk("reset_illegal", {13'h0, illegal}, 14'h0);

      // RUN already high when reset releases counts as a rising edge.
      run = 1'b1;
      tick();
      chk("reset_held", obs, 14'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("first_fetch", obs, B_FETCH | B_IRL);

      for (int i = 0; i < 12; i++)
         run_instr($sformatf("tbl%0d", i), tbl[i].opc, tbl[i].acc, 1'b0,
                   tbl[i].exp1, tbl[i].exp2, tbl[i].two);

      // STP halts; RUN held high keeps it halted until a fresh edge.
      run_instr("stp", 4'd7, 16'h0, 1'b0, B_E1 | B_CNT, 14'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stp_hold", obs, B_HALT);
      end
      resume("stp");

      // Single-step: each RUN pulse executes exactly one instruction.
      run_model("step_add1", 4'd2, 16'h0003, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("step_wait", obs, 14'h0);
      end
      resume("step1");
      run_model("step_add2", 4'd2, 16'h0004, 1'b1);
      tick();
      chk("step_wait2", obs, 14'h0);
      step = 1'b0;
      resume("step2");

      // Illegal opcode executes as a NOP and latches the sticky flag.
      run_instr("ill_b", 4'hB, 16'h0, 1'b0, B_E1 | B_CNT, 14'h0, 1'b0);
      run_model("after_ill", 4'd8, 16'h0, 1'b0);

      // Reset mid-instruction drops strobes asynchronously.
      ir = 4'd1; acc = 16'h0;
      tick();
      chk("rst_sta_exec1", obs, B_E1 | B_MUX1 | B_WREN | B_CNT);
      #2 rst = 1'b1;
      #1;
      chk("rst_async", obs, 14'h0);
      chk("rst_illegal_clr", {13'h0, illegal}, 14'h0);
      exp_illegal = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst_refetch", obs, B_FETCH | B_IRL);

      for (int n = 0; n < 200; n++) begin
         logic [OPC_W-1:0]  o;
         logic [DATA_W-1:0] a;
         o = OPC_W'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: a = '0;
            1: a = 16'h8000 | DATA_W'($urandom_range(0, 16'h7FFF));
            default: a = DATA_W'($urandom);
         endcase
         run_model($sformatf("rnd%0d_op%0d", n, o), o, a, 1'b0);
         if (o == 4'd7) resume("rnd_stp");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
